// File: rtl/rv32i_decode_exec.sv
// rv32i_decode_exec: RV32I decode, immediate generation and ALU with a registered output stage
module rv32i_decode_exec (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] instr,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] alu_result,
    output logic [31:0] imm_ext,
    output logic [3:0]  alu_control,
    output logic        alu_src,
    output logic [1:0]  pc_src,
    output logic [2:0]  result_src,
    output logic [2:0]  instr_type,
    output logic        illegal
);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7_5;
    logic        i31;
    logic [3:0]  d_ctl, a_ctl, b_ctl;
    logic        d_asrc, d_ill;
    logic [1:0]  d_pc;
    logic [2:0]  d_rsrc, d_ty;
    logic [31:0] d_imm, op2, d_res;
    logic [4:0]  sh;
    logic        lt, ltu;

    assign op   = instr[6:0];
    assign f3   = instr[14:12];
    assign f7_5 = instr[30];
    assign i31  = instr[31];

    // Branch conditions live at codes 10..15; funct3 010/011 have no encoding and fall back to ADD
    assign b_ctl = f3[2] ? 4'd12 + {2'b00, f3[1:0]} : (f3[1] ? 4'd0 : 4'd10 + {3'b000, f3[0]});

    // Arithmetic op from funct3; bit 30 picks SUB only for register-register adds, SRA for both shift forms
    always_comb begin
        a_ctl = 4'd0;
        case (f3)
            3'b000: a_ctl = (op == 7'b0110011 && f7_5) ? 4'd1 : 4'd0;
            3'b001: a_ctl = 4'd2;
            3'b010: a_ctl = 4'd3;
            3'b011: a_ctl = 4'd4;
            3'b100: a_ctl = 4'd5;
            3'b101: a_ctl = f7_5 ? 4'd7 : 4'd6;
            3'b110: a_ctl = 4'd8;
            default: a_ctl = 4'd9;
        endcase
    end

    // Opcode decode; defaults describe the unsupported-opcode case
    always_comb begin
        d_ill  = 1'b0;
        d_ty   = 3'd7;
        d_ctl  = 4'd0;
        d_asrc = 1'b0;
        d_pc   = 2'd0;
        d_rsrc = 3'd5;
        case (op)
            7'b0110111: begin d_ty = 3'd4; d_rsrc = 3'd1; end
            7'b0010111: begin d_ty = 3'd4; d_rsrc = 3'd2; end
            7'b1101111: begin d_ty = 3'd5; d_pc = 2'd1; d_rsrc = 3'd3; end
            7'b1100111: begin d_ty = 3'd1; d_pc = 2'd2; d_rsrc = 3'd3; d_asrc = 1'b1; end
            7'b1100011: begin d_ty = 3'd3; d_pc = 2'd3; d_ctl = b_ctl; d_ill = (f3[2:1] == 2'b01); end
            7'b0000011: begin d_ty = 3'd1; d_asrc = 1'b1; d_rsrc = 3'd4; end
            7'b0100011: begin d_ty = 3'd2; d_asrc = 1'b1; end
            7'b0010011: begin d_ty = 3'd1; d_asrc = 1'b1; d_rsrc = 3'd0; d_ctl = a_ctl; end
            7'b0110011: begin d_ty = 3'd0; d_rsrc = 3'd0; d_ctl = a_ctl; end
            default:    d_ill = 1'b1;
        endcase
    end

    assign d_imm = d_ty == 3'd1 ? {{20{i31}}, instr[31:20]} :
                   d_ty == 3'd2 ? {{20{i31}}, instr[31:25], instr[11:7]} :
                   d_ty == 3'd3 ? {{19{i31}}, i31, instr[7], instr[30:25], instr[11:8], 1'b0} :
                   d_ty == 3'd4 ? {instr[31:12], 12'b0} :
                   d_ty == 3'd5 ? {{11{i31}}, i31, instr[19:12], instr[20], instr[30:21], 1'b0} : 32'd0;

    assign op2 = d_asrc ? d_imm : rs2;
    assign sh  = op2[4:0];
    assign lt  = $signed(rs1) < $signed(op2);
    assign ltu = rs1 < op2;

    // ALU; comparison codes produce a 0/1 word
    always_comb begin
        d_res = 32'd0;
        case (d_ctl)
            4'd0:  d_res = rs1 + op2;
            4'd1:  d_res = rs1 - op2;
            4'd2:  d_res = rs1 << sh;
            4'd3:  d_res = {31'd0, lt};
            4'd4:  d_res = {31'd0, ltu};
            4'd5:  d_res = rs1 ^ op2;
            4'd6:  d_res = rs1 >> sh;
            4'd7:  d_res = $unsigned($signed(rs1) >>> sh);
            4'd8:  d_res = rs1 | op2;
            4'd9:  d_res = rs1 & op2;
            4'd10: d_res = {31'd0, rs1 == op2};
            4'd11: d_res = {31'd0, rs1 != op2};
            4'd12: d_res = {31'd0, lt};
            4'd13: d_res = {31'd0, !lt};
            4'd14: d_res = {31'd0, ltu};
            default: d_res = {31'd0, !ltu};
        endcase
    end

    // Output register: cleared asynchronously, loaded only when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result  <= '0;
            imm_ext     <= '0;
            alu_control <= '0;
            alu_src     <= 1'b0;
            pc_src      <= '0;
            result_src  <= '0;
            instr_type  <= '0;
            illegal     <= 1'b0;
        end else if (en) begin
            alu_result  <= d_res;
            imm_ext     <= d_imm;
            alu_control <= d_ctl;
            alu_src     <= d_asrc;
            pc_src      <= d_pc;
            result_src  <= d_rsrc;
            instr_type  <= d_ty;
            illegal     <= d_ill;
        end
    end
endmodule

// File: tb/tb_rv32i_decode_exec.sv
// tb_rv32i_decode_exec: directed scoreboard bench for rv32i_decode_exec
module tb_rv32i_decode_exec;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [31:0] instr, rs1, rs2;
    logic [31:0] alu_result, imm_ext;
    logic [3:0]  alu_control;
    logic        alu_src, illegal;
    logic [1:0]  pc_src;
    logic [2:0]  result_src, instr_type;

    typedef struct {
        logic [31:0] res;
        logic [31:0] imm;
        logic [3:0]  ctl;
        logic        asrc;
        logic [1:0]  pc;
        logic [2:0]  rsrc;
        logic [2:0]  ty;
        logic        ill;
        logic [7:0]  m;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int n_assert = 0;
    int n_fail = 0;

    rv32i_decode_exec dut (
        .clk(clk), .rst(rst), .en(en), .instr(instr), .rs1(rs1), .rs2(rs2),
        .alu_result(alu_result), .imm_ext(imm_ext), .alu_control(alu_control),
        .alu_src(alu_src), .pc_src(pc_src), .result_src(result_src),
        .instr_type(instr_type), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        if (e.m[0]) chk({e.tag, ".alu_result"},  alu_result, e.res);
        if (e.m[1]) chk({e.tag, ".imm_ext"},     imm_ext, e.imm);
        if (e.m[2]) chk({e.tag, ".alu_control"}, {28'd0, alu_control}, {28'd0, e.ctl});
        if (e.m[3]) chk({e.tag, ".alu_src"},     {31'd0, alu_src}, {31'd0, e.asrc});
        if (e.m[4]) chk({e.tag, ".pc_src"},      {30'd0, pc_src}, {30'd0, e.pc});
        if (e.m[5]) chk({e.tag, ".result_src"},  {29'd0, result_src}, {29'd0, e.rsrc});
        if (e.m[6]) chk({e.tag, ".instr_type"},  {29'd0, instr_type}, {29'd0, e.ty});
        if (e.m[7]) chk({e.tag, ".illegal"},     {31'd0, illegal}, {31'd0, e.ill});
    endtask

    function automatic exp_t mk(input string tag, input logic [31:0] res, imm, input logic [3:0] ctl,
                                input logic asrc, input logic [1:0] pc, input logic [2:0] rsrc, ty,
                                input logic ill, input logic [7:0] m);
        exp_t e;
        e.tag = tag; e.res = res; e.imm = imm; e.ctl = ctl; e.asrc = asrc;
        e.pc = pc; e.rsrc = rsrc; e.ty = ty; e.ill = ill; e.m = m;
        return e;
    endfunction

    task automatic step(input logic [31:0] i, a, b, input logic e_en, input exp_t e);
        @(negedge clk);
        instr = i; rs1 = a; rs2 = b; en = e_en;
        sb.push_back(e);
        if (e.m == 8'hFF) last = e;
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    initial begin
        exp_t z;
        z = mk("reset", 32'd0, 32'd0, 4'd0, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 8'hFF);
        rst = 1'b1; en = 1'b1; instr = 32'hFFF00093; rs1 = 32'd5; rs2 = 32'd0;
        #1;
        sb.push_back(z); pop_cmp();
        @(posedge clk); #1;
        z.tag = "reset_clocked"; sb.push_back(z); pop_cmp();
        @(negedge clk) rst = 1'b0;

        step(32'hFFF00093, 32'd5, 32'd0, 1'b1, mk("addi", 32'd4, 32'hFFFFFFFF, 4'd0, 1'b1, 2'd0, 3'd0, 3'd1, 1'b0, 8'hFF));
        step(32'h40208033, 32'd3, 32'd5, 1'b1, mk("sub", 32'hFFFFFFFE, 32'd0, 4'd1, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 8'hFF));
        step(32'h4010D093, 32'h80000000, 32'd0, 1'b1, mk("srai", 32'hC0000000, 32'h00000401, 4'd7, 1'b1, 2'd0, 3'd0, 3'd1, 1'b0, 8'hFF));
        step(32'h00208463, 32'd7, 32'd7, 1'b1, mk("beq_t", 32'd1, 32'd8, 4'd10, 1'b0, 2'd3, 3'd0, 3'd3, 1'b0, 8'hDF));
        step(32'h00208463, 32'd7, 32'd6, 1'b1, mk("beq_nt", 32'd0, 32'd8, 4'd10, 1'b0, 2'd3, 3'd0, 3'd3, 1'b0, 8'hDF));
        step(32'h0020E463, 32'd1, 32'hFFFFFFFF, 1'b1, mk("bltu", 32'd1, 32'd8, 4'd14, 1'b0, 2'd3, 3'd0, 3'd3, 1'b0, 8'hDF));
        step(32'h0020C463, 32'd1, 32'hFFFFFFFF, 1'b1, mk("blt", 32'd0, 32'd8, 4'd12, 1'b0, 2'd3, 3'd0, 3'd3, 1'b0, 8'hDF));
        step(32'h0020A463, 32'd1, 32'd2, 1'b1, mk("bill", 32'd0, 32'd0, 4'd0, 1'b0, 2'd0, 3'd0, 3'd0, 1'b1, 8'h80));
        step(32'h0020B0B3, 32'd1, 32'hFFFFFFFF, 1'b1, mk("sltu", 32'd1, 32'd0, 4'd4, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 8'hFF));
        step(32'h002090B3, 32'd1, 32'h00000021, 1'b1, mk("sll", 32'd2, 32'd0, 4'd2, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 8'hFF));
        step(32'h123450B7, 32'd0, 32'd0, 1'b1, mk("lui", 32'd0, 32'h12345000, 4'd0, 1'b0, 2'd0, 3'd1, 3'd4, 1'b0, 8'hF2));
        step(32'h0000007F, 32'd10, 32'd20, 1'b1, mk("illegal", 32'd30, 32'd0, 4'd0, 1'b0, 2'd0, 3'd5, 3'd7, 1'b1, 8'hFF));
        step(32'h12345097, 32'd0, 32'd0, 1'b1, mk("auipc", 32'd0, 32'h12345000, 4'd0, 1'b0, 2'd0, 3'd2, 3'd4, 1'b0, 8'hF2));
        step(32'h008000EF, 32'd0, 32'd0, 1'b1, mk("jal", 32'd0, 32'd8, 4'd0, 1'b0, 2'd1, 3'd3, 3'd5, 1'b0, 8'hF2));
        step(32'h00408067, 32'h100, 32'd0, 1'b1, mk("jalr", 32'h104, 32'd4, 4'd0, 1'b1, 2'd2, 3'd3, 3'd1, 1'b0, 8'hFF));
        step(32'hFE20AE23, 32'h1000, 32'd9, 1'b1, mk("sw", 32'h00000FFC, 32'hFFFFFFFC, 4'd0, 1'b1, 2'd0, 3'd5, 3'd2, 1'b0, 8'hFF));

        last.tag = "hold1";
        step(32'h40208033, 32'd3, 32'd5, 1'b0, last);
        last.tag = "hold2";
        step(32'h0000007F, 32'd1, 32'd1, 1'b0, last);

        step(32'h0000007F, 32'd10, 32'd20, 1'b1, mk("pre_rst", 32'd30, 32'd0, 4'd0, 1'b0, 2'd0, 3'd5, 3'd7, 1'b1, 8'hFF));
        #2 rst = 1'b1;
        #1;
        z.tag = "async_rst"; sb.push_back(z); pop_cmp();
        @(posedge clk); #1;
        z.tag = "rst_held"; sb.push_back(z); pop_cmp();
        @(negedge clk) rst = 1'b0;
        step(32'hFFF00093, 32'd5, 32'd0, 1'b1, mk("post_rst", 32'd4, 32'hFFFFFFFF, 4'd0, 1'b1, 2'd0, 3'd0, 3'd1, 1'b0, 8'hFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_decode_exec.md
RV32I_DECODE_EXEC -- requirements
Module: rv32i_decode_exec

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 SHALL have one clock and an asynchronous active-high reset; port clk (in, 1): rising-edge clock for all state.
REQ-003 port rst (in, 1): reset, asynchronous, active-high.
REQ-004 port en (in, 1): capture enable for the output register stage.
REQ-005 port instr (in, 32): RV32I instruction word.
REQ-006 port rs1 (in, 32): register operand 1 value.
REQ-007 port rs2 (in, 32): register operand 2 value.
REQ-008 port alu_result (out, 32): registered ALU result.
REQ-009 port imm_ext (out, 32): registered sign-extended immediate.
REQ-010 port alu_control (out, 4): registered ALU operation code.
REQ-011 port alu_src (out, 1): registered ALU input-2 select; 1 = imm_ext, 0 = rs2.
REQ-012 port pc_src (out, 2): registered next-PC select.
  - 0: pc+4
  - 1: pc+imm (JAL)
  - 2: rs1+imm, bit0 cleared (JALR)
  - 3: branch; pc+imm if alu_result[0] else pc+4
REQ-013 port result_src (out, 3): registered writeback select.
  - 0: ALU
  - 1: imm (LUI)
  - 2: pc+imm (AUIPC)
  - 3: pc+4 (JAL/JALR)
  - 4: memory (LOAD)
  - 5: none
REQ-014 port instr_type (out, 3): registered format code.
  - 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 invalid
REQ-015 port illegal (out, 1): registered unsupported-opcode flag.

Function
REQ-016 Decode, immediate generation and ALU SHALL be combinational from instr/rs1/rs2. All outputs SHALL be captured on the rising clk edge when en=1, giving 1-cycle latency; outputs SHALL hold when en=0.
REQ-017 Opcode map:
  - LUI 0110111 (U, result 1)
  - AUIPC 0010111 (U, result 2)
  - JAL 1101111 (J, pc 1, result 3)
  - JALR 1100111 (I, pc 2, result 3, ADD, alu_src 1)
  - BRANCH 1100011 (B, pc 3, alu_src 0)
  - LOAD 0000011 (I, ADD, alu_src 1, result 4)
  - STORE 0100011 (S, ADD, alu_src 1, result 5)
  - OP_IMM 0010011 (I, alu_src 1, result 0)
  - OP 0110011 (R, alu_src 0, result 0)
  - pc_src SHALL be 0 unless stated.
REQ-018 Any other opcode SHALL decode as: illegal=1, instr_type 7, ADD, alu_src 0, pc_src 0, result_src 5, imm_ext 0.
REQ-019 alu_control codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU
  - Codes 10-15 SHALL yield 32'd1 if the condition is true, else 0.
REQ-020 funct3 mapping for OP and OP_IMM: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - funct7_5 (instr[30]) = 1 selects SUB for OP/000.
  - funct7_5 = 1 selects SRA for 101 in both OP and OP_IMM.
  - OP_IMM/000 SHALL always be ADD.
REQ-021 BRANCH funct3 mapping: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. funct3 010/011 SHALL set illegal=1.
REQ-022 Shifts SHALL use only operand2[4:0]. SRA SHALL be arithmetic. SLT/LT/GE SHALL compare signed; SLTU/LTU/GEU SHALL compare unsigned. ADD/SUB SHALL wrap modulo 2^32.
REQ-023 Immediate formats:
  - I = sext(instr[31:20])
  - S = sext({instr[31:25],instr[11:7]})
  - B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0})
  - U = {instr[31:12],12'b0}
  - J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0})
  - R = 0
REQ-024 ALU operand1 SHALL be rs1. ALU operand2 SHALL be imm_ext when alu_src=1, else rs2.

Reset
REQ-025 While rst=1, all outputs SHALL be 0, asynchronously, regardless of clk/en; this includes instr_type 0, illegal 0 and result_src 0.
REQ-026 Reset asserted mid-operation SHALL discard any pending capture. The first capture after rst deasserts SHALL occur on the next rising edge with en=1.

Verification
REQ-027 instr=0xFFF00093, rs1=5, en=1, one edge -> alu_result=4, imm_ext=0xFFFFFFFF, instr_type=1, alu_src=1, result_src=0.
REQ-028 instr=0x40208033, rs1=3, rs2=5 -> alu_control=1, alu_result=0xFFFFFFFE, instr_type=0, imm_ext=0.
REQ-029 instr=0x4010D093, rs1=0x80000000 -> alu_control=7, alu_result=0xC0000000.
REQ-030 instr=0x00208463:
  - rs1=rs2=7 -> imm_ext=8, alu_control=10, alu_result=1, pc_src=3, instr_type=3.
  - rs2=6 -> alu_result=0.
REQ-031 instr=0x123450B7 -> imm_ext=0x12345000, result_src=1, instr_type=4. Then instr=0x0000007F -> illegal=1, instr_type=7, result_src=5.
REQ-032 Reset and enable behaviour:
  - Capture any instruction, assert rst between edges -> all outputs 0 immediately.
  - en=0 edges -> outputs unchanged.
